// File: rtl/host_bus_arbiter.sv
`timescale 1ns/1ps
// host_bus_arbiter
// ----------------
// Round-robin arbiter and sequencer that shares one register-access bus
// master port between N_REQ transaction requesters. Each accepted request
// is tagged with a running index and issued on the bus. The arbiter then
// waits for completion or timeout and returns the result to the requester
// that issued it. Only one transaction is outstanding at any time.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req_valid/ready   : per-requester request / one-hot combinational grant
//   req_we/addr/be/wdata : packed request fields, requester i uses slice i
//   rsp_valid         : one-hot single-cycle completion pulse to the owner
//   rsp_rdata/err/idx : registered completion data / error / index
//   m_valid/m_ready   : bus command handshake
//   m_we/addr/be/wdata/idx : registered bus command fields
//   m_rvalid/rdata/err: bus completion
//
// Handshakes
//   A request transfers on the cycle where req_valid[i] and req_ready[i]
//   are both high. req_ready is only raised in IDLE, for the chosen
//   requester. A bus command transfers on the cycle where m_valid and
//   m_ready are both high, and m_* stay stable while m_valid is high. A
//   completion is one m_rvalid cycle. It counts in WAIT, or in ISSUE on the
//   same cycle as m_ready. At any other time it is ignored.
module host_bus_arbiter #(
    parameter int N_REQ   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int IDX_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*AW-1:0]     req_addr,
    input  logic [N_REQ*(DW/8)-1:0] req_be,
    input  logic [N_REQ*DW-1:0]     req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DW-1:0]           rsp_rdata,
    output logic                    rsp_err,
    output logic [IDX_W-1:0]        rsp_idx,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_we,
    output logic [AW-1:0]           m_addr,
    output logic [DW/8-1:0]         m_be,
    output logic [DW-1:0]           m_wdata,
    output logic [IDX_W-1:0]        m_idx,
    input  logic                    m_rvalid,
    input  logic [DW-1:0]           m_rdata,
    input  logic                    m_err
);

    localparam int BW = DW / 8;
    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // last_q is the most recent grant. It is also the owner of the
    // in-flight transaction, so rsp_valid is steered by it.
    logic [LW-1:0]     last_q;
    logic [IDX_W-1:0]  idx_cnt;
    logic [TW-1:0]     tmo_cnt;

    logic              grant_found;
    logic [LW-1:0]     grant_idx;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [BW-1:0]     sel_be;
    logic [DW-1:0]     sel_wdata;

    logic              grant_fire;
    logic              busy;
    logic              cpl_fire;
    logic              tmo_hit;
    logic              tmo_fire;

    // Round-robin search starting one past the previous grant.
    always_comb begin
        int cand;
        cand        = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(last_q) + 1 + k) % N_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = LW'(cand);
            end
        end
    end

    // Select the fields of the granted requester.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == LW'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_be    = req_be[i*BW +: BW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    assign grant_fire = (state_q == ST_IDLE) && grant_found;
    assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign cpl_fire   = ((state_q == ST_ISSUE) && m_ready && m_rvalid) ||
                        ((state_q == ST_WAIT) && m_rvalid);
    // A completion on the last allowed cycle still wins over the timeout.
    assign tmo_hit    = busy && (tmo_cnt == TW'(TIMEOUT - 1));
    assign tmo_fire   = tmo_hit && !cpl_fire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cpl_fire || tmo_hit) state_d = ST_RESP;
                else if (m_ready)        state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cpl_fire || tmo_hit) state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic. req_ready is held low while reset is asserted so that
    // no acceptance is advertised on a cycle that cannot capture.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        m_valid   = (state_q == ST_ISSUE);
        for (int i = 0; i < N_REQ; i++) begin
            if (rst_n && grant_fire && (grant_idx == LW'(i))) req_ready[i] = 1'b1;
            if ((state_q == ST_RESP) && (last_q == LW'(i)))   rsp_valid[i] = 1'b1;
        end
    end

    // Datapath: grant bookkeeping, command fields, timeout and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= LW'(N_REQ - 1);
            idx_cnt   <= '0;
            tmo_cnt   <= '0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_be      <= '0;
            m_wdata   <= '0;
            m_idx     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_idx   <= '0;
        end else begin
            // Cleared outside ISSUE/WAIT so it is 0 on entry to ISSUE.
            if (busy) tmo_cnt <= tmo_cnt + 1'b1;
            else      tmo_cnt <= '0;

            if (grant_fire) begin
                last_q  <= grant_idx;
                m_we    <= sel_we;
                m_addr  <= sel_addr;
                m_be    <= sel_be;
                m_wdata <= sel_wdata;
                m_idx   <= idx_cnt;
                idx_cnt <= idx_cnt + 1'b1;
            end

            if (cpl_fire) begin
                rsp_rdata <= (m_we || m_err) ? '0 : m_rdata;
                rsp_err   <= m_err;
                rsp_idx   <= m_idx;
            end else if (tmo_fire) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
                rsp_idx   <= m_idx;
            end
        end
    end

endmodule

// File: tb/tb_host_bus_arbiter.sv
`timescale 1ns/1ps
module tb_host_bus_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int IW  = 4;
    localparam int TMO = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW/8-1:0] req_be;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [IW-1:0]     rsp_idx;
    logic              m_valid;
    logic              m_ready;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [DW/8-1:0]   m_be;
    logic [DW-1:0]     m_wdata;
    logic [IW-1:0]     m_idx;
    logic              m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic              m_err;

    host_bus_arbiter #(
        .N_REQ(N), .AW(AW), .DW(DW), .IDX_W(IW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_idx(rsp_idx), .m_valid(m_valid), .m_ready(m_ready),
        .m_we(m_we), .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata),
        .m_idx(m_idx), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [63:0] addr;      // {req1, req0}
        logic [7:0]  be;
        logic [63:0] wdata;
        int          rdy_dly;   // ISSUE cycles before m_ready
        int          rsp_dly;   // cycles from m_ready to m_rvalid (0 = same cycle)
        logic [31:0] s_rdata;
        logic        s_err;
        int          exp_g;
        logic [3:0]  exp_idx;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                                input logic [63:0] addr, input logic [7:0] be,
                                input logic [63:0] wdata, input int rdy, input int rsp,
                                input logic [31:0] srd, input logic serr, input int g,
                                input logic [3:0] idx, input logic [31:0] erd,
                                input logic eerr);
        vec_t v;
        v.valid = valid; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
        v.rdy_dly = rdy; v.rsp_dly = rsp; v.s_rdata = srd; v.s_err = serr;
        v.exp_g = g; v.exp_idx = idx; v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    // ---------------- driver ----------------
    // Cycle 0 is the IDLE cycle that presents the request. The slave side
    // is driven per cycle from the vector, and the response is checked on
    // the cycle after the completion.
    task automatic do_txn(input vec_t v, input int id);
        int         done_c;
        int         g;
        logic [1:0] exp_oh;
        g      = v.exp_g;
        exp_oh = 2'b01 << g;
        done_c = 1 + v.rdy_dly + v.rsp_dly;
        @(negedge clk);
        req_valid = v.valid; req_we = v.we; req_addr = v.addr;
        req_be = v.be; req_wdata = v.wdata;
        m_ready = 1'b0; m_rvalid = 1'b0; m_err = 1'b0; m_rdata = 32'hDEAD_BEEF;
        #1;
        check($sformatf("t%0d req_ready", id), req_ready, exp_oh);
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = req_valid & ~exp_oh;
            m_ready  = (c == 1 + v.rdy_dly);
            m_rvalid = (c == done_c);
            m_rdata  = (c == done_c) ? v.s_rdata : 32'hDEAD_BEEF;
            m_err    = (c == done_c) ? v.s_err : 1'b0;
            #1;
            if (c == 1) begin
                check($sformatf("t%0d m_valid", id), m_valid, 1'b1);
                check($sformatf("t%0d m_we", id), m_we, v.we[g]);
                check($sformatf("t%0d m_addr", id), m_addr, v.addr[g*32 +: 32]);
                check($sformatf("t%0d m_be", id), m_be, v.be[g*4 +: 4]);
                check($sformatf("t%0d m_wdata", id), m_wdata, v.wdata[g*32 +: 32]);
                check($sformatf("t%0d m_idx", id), m_idx, v.exp_idx);
            end
            if (c == done_c)
                check($sformatf("t%0d rsp_early", id), rsp_valid, 2'b00);
            if (c == done_c + 1) begin
                check($sformatf("t%0d rsp_valid", id), rsp_valid, exp_oh);
                check($sformatf("t%0d rsp_rdata", id), rsp_rdata, v.exp_rdata);
                check($sformatf("t%0d rsp_err", id), rsp_err, v.exp_err);
                check($sformatf("t%0d rsp_idx", id), rsp_idx, v.exp_idx);
                m_ready = 1'b0; m_rvalid = 1'b0; m_err = 1'b0;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " req_ready"}, req_ready, 2'b00);
        check({tag, " rsp_valid"}, rsp_valid, 2'b00);
        check({tag, " m_valid"}, m_valid, 1'b0);
        check({tag, " rsp_err"}, rsp_err, 1'b0);
        check({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, " rsp_idx"}, rsp_idx, 4'h0);
        check({tag, " m_we"}, m_we, 1'b0);
        check({tag, " m_addr"}, m_addr, 32'h0);
        check({tag, " m_be"}, m_be, 4'h0);
        check({tag, " m_wdata"}, m_wdata, 32'h0);
        check({tag, " m_idx"}, m_idx, 4'h0);
    endtask

    // Watchdog: every wait below is a fixed cycle count, this only guards
    // against an unexpected hang.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl [10];

    initial begin
        int hi_cnt;
        int rsp_cnt;
        vec_t v;

        tbl[0] = mk(2'b11, 2'b11, {32'h24, 32'h20}, 8'hC3, {32'h2222_2222, 32'h1111_1111},
                    0, 0, 32'h5555_AAAA, 1'b0, 0, 4'd0, 32'h0, 1'b0);
        tbl[1] = mk(2'b11, 2'b11, {32'h24, 32'h20}, 8'hC3, {32'h2222_2222, 32'h1111_1111},
                    0, 0, 32'h5555_AAAA, 1'b0, 1, 4'd1, 32'h0, 1'b0);
        tbl[2] = mk(2'b11, 2'b11, {32'h24, 32'h20}, 8'hC3, {32'h2222_2222, 32'h1111_1111},
                    0, 0, 32'h5555_AAAA, 1'b0, 0, 4'd2, 32'h0, 1'b0);
        tbl[3] = mk(2'b11, 2'b11, {32'h24, 32'h20}, 8'hC3, {32'h2222_2222, 32'h1111_1111},
                    0, 0, 32'h5555_AAAA, 1'b0, 1, 4'd3, 32'h0, 1'b0);
        tbl[4] = mk(2'b01, 2'b00, {32'h0, 32'h10}, 8'h0F, 64'h0,
                    0, 0, 32'hCAFE_0001, 1'b0, 0, 4'd4, 32'hCAFE_0001, 1'b0);
        tbl[5] = mk(2'b10, 2'b00, {32'h30, 32'h0}, 8'hF0, 64'h0,
                    0, 3, 32'h1234_5678, 1'b1, 1, 4'd5, 32'h0, 1'b1);
        tbl[6] = mk(2'b11, 2'b00, {32'h54, 32'h50}, 8'h21, 64'h0,
                    2, 1, 32'hA5A5_0006, 1'b0, 0, 4'd6, 32'hA5A5_0006, 1'b0);
        tbl[7] = mk(2'b10, 2'b00, {32'h60, 32'h0}, 8'hF0, 64'h0,
                    0, 0, 32'h0BAD_F00D, 1'b0, 1, 4'd7, 32'h0BAD_F00D, 1'b0);
        tbl[8] = mk(2'b01, 2'b01, {32'h0, 32'h70}, 8'h0F, {32'h0, 32'h89AB_CDEF},
                    1, 0, 32'hFFFF_FFFF, 1'b0, 0, 4'd8, 32'h0, 1'b0);
        tbl[9] = mk(2'b01, 2'b00, {32'h0, 32'h74}, 8'h0F, 64'h0,
                    0, 2, 32'h1357_9BDF, 1'b0, 0, 4'd9, 32'h1357_9BDF, 1'b0);

        rst_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_be = '0; req_wdata = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;

        // Table: alternation, zero-wait read, error after WAIT, delayed ready,
        // write with returned data, single requester repeat.
        for (int i = 0; i < 10; i++) do_txn(tbl[i], i);

        // Timeout by requester 1, idx 10; then a stray late completion.
        @(negedge clk);
        req_valid = 2'b10; req_we = 2'b00; req_addr = {32'h40, 32'h0};
        req_be = 8'hF0; req_wdata = '0;
        m_ready = 1'b0; m_rvalid = 1'b0;
        #1;
        check("tmo req_ready", req_ready, 2'b10);
        hi_cnt = 0;
        rsp_cnt = 0;
        for (int c = 1; c <= TMO; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 2'b00;
            #1;
            if (m_valid) hi_cnt++;
            if (rsp_valid != 2'b00) rsp_cnt++;
        end
        check("tmo m_valid_cycles", hi_cnt, TMO);
        check("tmo rsp_before", rsp_cnt, 0);
        @(negedge clk);
        #1;
        check("tmo m_valid_low", m_valid, 1'b0);
        check("tmo rsp_valid", rsp_valid, 2'b10);
        check("tmo rsp_err", rsp_err, 1'b1);
        check("tmo rsp_rdata", rsp_rdata, 32'h0);
        check("tmo rsp_idx", rsp_idx, 4'd10);
        rsp_cnt = 0;
        for (int c = 18; c <= 26; c++) begin
            @(negedge clk);
            m_rvalid = (c == 22);
            m_rdata  = 32'h7777_7777;
            #1;
            if (rsp_valid != 2'b00) rsp_cnt++;
        end
        check("late_cpl rsp_count", rsp_cnt, 0);

        // Reset during WAIT (idx 11 in flight).
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; req_addr = {32'h0, 32'hABC};
        req_be = 8'h0F; req_wdata = '0; m_rvalid = 1'b0;
        #1;
        check("rst req_ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00; m_ready = 1'b1;
        #1;
        check("rst m_idx", m_idx, 4'd11);
        @(negedge clk);
        m_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != 2'b00 || m_valid) rsp_cnt++;
        end
        check("midrst quiet", rsp_cnt, 0);

        // After reset: requester 0 wins first with idx 0, then 16 more
        // transactions so that the 17th wraps back to idx 0.
        for (int k = 0; k < 17; k++) begin
            v.valid     = (k == 0) ? 2'b11 : 2'b01;
            v.we        = {1'b0, k[0]};
            v.addr      = {32'h0, 32'h10 + 32'(k * 4)};
            v.be        = 8'h0F;
            v.wdata     = {32'h0, 32'hA000_0000 + 32'(k)};
            v.rdy_dly   = 0;
            v.rsp_dly   = 0;
            v.s_rdata   = (k == 0) ? 32'hCAFE_0001 : 32'hB000_0000 + 32'(k);
            v.s_err     = 1'b0;
            v.exp_g     = 0;
            v.exp_idx   = 4'(k % 16);
            v.exp_rdata = k[0] ? 32'h0 : v.s_rdata;
            v.exp_err   = 1'b0;
            do_txn(v, 100 + k);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
